// File: rtl/idct_terim_biriktirici_if.sv
// Term-input and sample-output bus of the IDCT term accumulator.
// Upstream sequencer and write-back stage both drive this bus; the accumulator takes the slave side.
interface idct_terim_biriktirici_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    // Handshake rule for both directions: a transfer happens on a rising edge
    // where valid && ready; the producer keeps its payload stable until then.
    logic [DATA_W-1:0] islem_matrix_i;
    logic [IDX_W-1:0]  islem_index_i;
    logic [DATA_W-1:0] islem_cos_mp_i;
    logic [DATA_W-1:0] islem_cos_nq_i;
    logic [DATA_W-1:0] islem_ap_i;
    logic [DATA_W-1:0] islem_aq_i;
    logic              islem_gecerli_i;
    logic              islem_hazir_o;
    logic [DATA_W-1:0] sonuc_veri_o;
    logic [IDX_W-1:0]  sonuc_index_o;
    logic              sonuc_tasma_o;
    logic              sonuc_gecerli_o;
    logic              sonuc_hazir_i;

    modport master (
        output islem_matrix_i, islem_index_i, islem_cos_mp_i, islem_cos_nq_i,
               islem_ap_i, islem_aq_i, islem_gecerli_i, sonuc_hazir_i,
        input  islem_hazir_o, sonuc_veri_o, sonuc_index_o, sonuc_tasma_o,
               sonuc_gecerli_o
    );

    modport slave (
        input  islem_matrix_i, islem_index_i, islem_cos_mp_i, islem_cos_nq_i,
               islem_ap_i, islem_aq_i, islem_gecerli_i, sonuc_hazir_i,
        output islem_hazir_o, sonuc_veri_o, sonuc_index_o, sonuc_tasma_o,
               sonuc_gecerli_o
    );
endinterface

// File: rtl/idct_terim_biriktirici.sv
// IDCT-II term pipeline: three Q-format multiply stages feeding an accumulator
// that emits one spatial sample per BLOCK_N*BLOCK_N accepted terms.
module idct_terim_biriktirici #(
    parameter int DATA_W   = 32,
    parameter int FRAC_W   = 16,
    parameter int IDX_W    = 6,
    parameter int BLOCK_N  = 8,
    parameter int ROUND    = 0,
    parameter int SATURATE = 1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    idct_terim_biriktirici_if.slave bus
);

    localparam int TERMS  = BLOCK_N * BLOCK_N;
    localparam int CNT_W  = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int ACC_W  = DATA_W + 2 * $clog2(BLOCK_N);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [PROD_W-1:0] RND_K =
        (ROUND != 0) ? (PROD_W'(1) << (FRAC_W - 1)) : '0;
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic                     ovf;
        logic signed [DATA_W-1:0] val;
    } qres_t;

    function automatic qres_t qmul(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
        logic signed [PROD_W-1:0] p;
        logic [PROD_W-DATA_W:0]   hi;
        qres_t                    r;
        p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        p = (p + RND_K) >>> FRAC_W;
        // Result fits only when everything above the kept sign bit is sign extension.
        hi    = p[PROD_W-1:DATA_W-1];
        r.val = p[DATA_W-1:0];
        r.ovf = 1'b0;
        if ((SATURATE != 0) && !(&hi) && (|hi)) begin
            r.val = p[PROD_W-1] ? MIN_V : MAX_V;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    logic                     s0_v, s1_v, s2_v;
    logic [IDX_W-1:0]         s0_idx, s1_idx, s2_idx;
    logic                     s0_ovf, s1_ovf, s2_ovf;
    logic signed [DATA_W-1:0] s0_cc, s0_aa, s0_mat, s1_k, s1_mat, s2_t;

    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic                     acc_ovf;
    logic [IDX_W-1:0]         acc_idx;

    logic                     out_v, out_ovf;
    logic [DATA_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_idx;

    qres_t cc_q, aa_q, k_q, t_q;
    logic  stall, first, last, ovf_grp, sum_clamp;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [ACC_W-DATA_W:0]    sum_hi;
    logic [IDX_W-1:0]         idx_grp;
    logic [DATA_W-1:0]        sum_out;

    assign stall = out_v & ~bus.sonuc_hazir_i;

    assign cc_q = qmul(bus.islem_cos_mp_i, bus.islem_cos_nq_i);
    assign aa_q = qmul(bus.islem_ap_i, bus.islem_aq_i);
    assign k_q  = qmul(s0_cc, s0_aa);
    assign t_q  = qmul(s1_k, s1_mat);

    // The first term of a group replaces the accumulator instead of adding to it.
    assign first     = (cnt == '0);
    assign last      = (cnt == CNT_W'(TERMS - 1));
    assign acc_sum   = (first ? '0 : acc) + {{(ACC_W-DATA_W){s2_t[DATA_W-1]}}, s2_t};
    assign ovf_grp   = s2_ovf | (~first & acc_ovf);
    assign idx_grp   = first ? s2_idx : acc_idx;
    assign sum_hi    = acc_sum[ACC_W-1:DATA_W-1];
    assign sum_clamp = (SATURATE != 0) && !(&sum_hi) && (|sum_hi);
    assign sum_out   = sum_clamp ? (acc_sum[ACC_W-1] ? MIN_V : MAX_V) : acc_sum[DATA_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_v     <= 1'b0;  s1_v   <= 1'b0;  s2_v   <= 1'b0;
            s0_idx   <= '0;    s1_idx <= '0;    s2_idx <= '0;
            s0_ovf   <= 1'b0;  s1_ovf <= 1'b0;  s2_ovf <= 1'b0;
            s0_cc    <= '0;    s0_aa  <= '0;    s0_mat <= '0;
            s1_k     <= '0;    s1_mat <= '0;    s2_t   <= '0;
            cnt      <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            acc_idx  <= '0;
            out_v    <= 1'b0;
            out_ovf  <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
        end else if (!stall) begin
            s0_v   <= bus.islem_gecerli_i;
            s0_idx <= bus.islem_index_i;
            s0_cc  <= cc_q.val;
            s0_aa  <= aa_q.val;
            s0_mat <= bus.islem_matrix_i;
            s0_ovf <= cc_q.ovf | aa_q.ovf;

            s1_v   <= s0_v;
            s1_idx <= s0_idx;
            s1_k   <= k_q.val;
            s1_mat <= s0_mat;
            s1_ovf <= s0_ovf | k_q.ovf;

            s2_v   <= s1_v;
            s2_idx <= s1_idx;
            s2_t   <= t_q.val;
            s2_ovf <= s1_ovf | t_q.ovf;

            // Not stalled means any pending sample is being taken this edge.
            out_v <= s2_v & last;
            if (s2_v) begin
                acc     <= acc_sum;
                acc_ovf <= ovf_grp;
                acc_idx <= idx_grp;
                cnt     <= last ? '0 : cnt + CNT_W'(1);
                if (last) begin
                    out_data <= sum_out;
                    out_idx  <= idx_grp;
                    out_ovf  <= ovf_grp | sum_clamp;
                end
            end
        end
    end

    assign bus.islem_hazir_o   = ~stall;
    assign bus.sonuc_veri_o    = out_data;
    assign bus.sonuc_index_o   = out_idx;
    assign bus.sonuc_tasma_o   = out_ovf;
    assign bus.sonuc_gecerli_o = out_v;

endmodule
